// File: rtl/floata_pkg.sv
// Shared constants and FSM state type for the FLOATA conversion scheduler.
package floata_pkg;

  localparam int DQ_W  = 16;
  localparam int DQ0_W = 11;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  // Latency counter width: ceil(log2(lat+1)), never below one bit.
  function automatic int cnt_width(input int lat);
    if (lat <= 1) return 1;
    return $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/floata_sched_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after last+1, wrapping.
module rr_arbiter #(
  parameter int NCH = 4
) (
  input  logic [NCH-1:0]         req,
  input  logic [$clog2(NCH)-1:0] last,
  output logic [NCH-1:0]         grant,
  output logic [$clog2(NCH)-1:0] idx
);

  localparam int IW = $clog2(NCH);

  logic [IW-1:0] cand;
  logic          found;

  // NCH is a power of two, so IW-bit addition wraps exactly modulo NCH.
  always_comb begin
    grant = '0;
    idx   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= NCH; k++) begin
      cand = last + IW'(k);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/floata_sched.sv
// Shares one external FLOATA converter among NCH requesters, one conversion in flight at a time.
module floata_sched
  import floata_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int FA_LAT = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NCH-1:0]         req,
  input  logic [NCH*DQ_W-1:0]    dq_in,
  output logic [NCH-1:0]         ack,
  output logic [DQ_W-1:0]        fa_dq,
  input  logic [DQ0_W-1:0]       fa_dq0,
  output logic [DQ0_W-1:0]       dq0_out,
  output logic                   dq0_valid,
  output logic [$clog2(NCH)-1:0] dq0_ch,
  output logic                   busy,
  input  logic                   scan_in0,
  input  logic                   scan_in1,
  input  logic                   scan_in2,
  input  logic                   scan_in3,
  input  logic                   scan_in4,
  input  logic                   scan_enable,
  input  logic                   test_mode,
  output logic                   scan_out0,
  output logic                   scan_out1,
  output logic                   scan_out2,
  output logic                   scan_out3,
  output logic                   scan_out4,
  output state_e                 state
);

  localparam int IW = $clog2(NCH);
  localparam int CW = cnt_width(FA_LAT);

  // Handshake: req[i] is held until ack[i] pulses; ack[i] means dq_in slice i
  // was captured on that edge. dq0_valid pulses once per grant and qualifies
  // dq0_out/dq0_ch for that single cycle; both then hold until the next capture.

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW-1:0]    last_q, last_d;
  logic [NCH-1:0]   ack_q, ack_d;
  logic [DQ_W-1:0]  fa_dq_q, fa_dq_d;
  logic [DQ0_W-1:0] dq0_out_q, dq0_out_d;
  logic [IW-1:0]    dq0_ch_q, dq0_ch_d;
  logic             dq0_valid_q, dq0_valid_d;

  logic [NCH-1:0]   grant;
  logic [IW-1:0]    win_idx;
  logic [DQ_W-1:0]  dq_sel;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req   (req),
    .last  (last_q),
    .grant (grant),
    .idx   (win_idx)
  );

  always_comb begin
    dq_sel = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant[i]) dq_sel = dq_sel | dq_in[i*DQ_W +: DQ_W];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= IW'(NCH - 1);
      ack_q       <= '0;
      fa_dq_q     <= '0;
      dq0_out_q   <= '0;
      dq0_ch_q    <= '0;
      dq0_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      ack_q       <= ack_d;
      fa_dq_q     <= fa_dq_d;
      dq0_out_q   <= dq0_out_d;
      dq0_ch_q    <= dq0_ch_d;
      dq0_valid_q <= dq0_valid_d;
    end
  end

  // last doubles as the owner of the conversion in flight.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    ack_d       = '0;
    fa_dq_d     = fa_dq_q;
    dq0_out_d   = dq0_out_q;
    dq0_ch_d    = dq0_ch_q;
    dq0_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          ack_d   = grant;
          fa_dq_d = dq_sel;
          last_d  = win_idx;
          cnt_d   = CW'(FA_LAT);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          dq0_out_d   = fa_dq0;
          dq0_ch_d    = last_q;
          dq0_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ack       = ack_q;
  assign fa_dq     = fa_dq_q;
  assign dq0_out   = dq0_out_q;
  assign dq0_ch    = dq0_ch_q;
  assign dq0_valid = dq0_valid_q;
  assign busy      = (state_q != IDLE);
  assign state     = state_q;

  assign scan_out0 = 1'b0;
  assign scan_out1 = 1'b0;
  assign scan_out2 = 1'b0;
  assign scan_out3 = 1'b0;
  assign scan_out4 = 1'b0;

  logic unused_scan;
  assign unused_scan = ^{scan_in0, scan_in1, scan_in2, scan_in3, scan_in4,
                         scan_enable, test_mode};

endmodule

// File: tb/tb_floata_sched.sv
// Bench for floata_sched: one instance with a behavioural FLOATA (FA_LAT=0), one with a 2-cycle echo stub (FA_LAT=2).
module tb_floata_sched;
  import floata_pkg::*;

  logic clk, reset, use_b;
  logic [3:0]  req_m;
  logic [63:0] dq_m;
  logic scan_in0, scan_in1, scan_in2, scan_in3, scan_in4, scan_enable, test_mode;

  logic [3:0]  req_a, req_b, ack_a, ack_b, ack_m;
  logic [63:0] dq_a, dq_b;
  logic [15:0] fa_dq_a, fa_dq_b, fa_dq_m;
  logic [10:0] fa_dq0_a, fa_dq0_b, dq0_out_a, dq0_out_b, dq0_out_m;
  logic [10:0] stub_s1, stub_s2;
  logic        dq0_valid_a, dq0_valid_b, dq0_valid_m, busy_a, busy_b, busy_m;
  logic [1:0]  dq0_ch_a, dq0_ch_b, dq0_ch_m;
  logic [4:0]  so_a, so_b;
  state_e      state_a, state_b, state_m;

  int checks = 0;
  int errors = 0;

  // Reference model: timeline of grant edges plus an expected-result queue.
  int          m_last, m_edge, m_gedge;
  logic [15:0] m_fa_dq;
  logic [10:0] m_out;
  logic [1:0]  m_ch;
  logic [3:0]  exp_ack;
  logic        exp_busy, exp_valid;
  logic [10:0] exp_q[$];
  logic [1:0]  exp_ch_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign req_a = use_b ? 4'b0 : req_m;
  assign req_b = use_b ? req_m : 4'b0;
  assign dq_a  = dq_m;
  assign dq_b  = dq_m;
  assign ack_m       = use_b ? ack_b       : ack_a;
  assign fa_dq_m     = use_b ? fa_dq_b     : fa_dq_a;
  assign dq0_out_m   = use_b ? dq0_out_b   : dq0_out_a;
  assign dq0_valid_m = use_b ? dq0_valid_b : dq0_valid_a;
  assign dq0_ch_m    = use_b ? dq0_ch_b    : dq0_ch_a;
  assign busy_m      = use_b ? busy_b      : busy_a;
  assign state_m     = use_b ? state_b     : state_a;

  // G.726 FLOATA: sign, 4-bit exponent, 6-bit normalised mantissa (32 for zero).
  function automatic logic [10:0] floata(input logic [15:0] dq);
    logic [14:0] mag;
    logic [20:0] sh;
    int e;
    mag = dq[14:0];
    e = 0;
    for (int i = 0; i < 15; i++) if (mag[i]) e = i + 1;
    if (mag == 15'd0) return {dq[15], 4'd0, 6'd32};
    sh = ({6'b0, mag} << 6) >> e;
    return {dq[15], 4'(e), sh[5:0]};
  endfunction

  assign fa_dq0_a = floata(fa_dq_a);

  always @(posedge clk) begin
    stub_s1 <= fa_dq_b[10:0];
    stub_s2 <= stub_s1;
  end
  assign fa_dq0_b = stub_s2;

  floata_sched #(.NCH(4), .FA_LAT(0)) dut_a (
    .clk(clk), .reset(reset), .req(req_a), .dq_in(dq_a), .ack(ack_a),
    .fa_dq(fa_dq_a), .fa_dq0(fa_dq0_a), .dq0_out(dq0_out_a),
    .dq0_valid(dq0_valid_a), .dq0_ch(dq0_ch_a), .busy(busy_a),
    .scan_in0(scan_in0), .scan_in1(scan_in1), .scan_in2(scan_in2),
    .scan_in3(scan_in3), .scan_in4(scan_in4), .scan_enable(scan_enable),
    .test_mode(test_mode), .scan_out0(so_a[0]), .scan_out1(so_a[1]),
    .scan_out2(so_a[2]), .scan_out3(so_a[3]), .scan_out4(so_a[4]),
    .state(state_a)
  );

  floata_sched #(.NCH(4), .FA_LAT(2)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .dq_in(dq_b), .ack(ack_b),
    .fa_dq(fa_dq_b), .fa_dq0(fa_dq0_b), .dq0_out(dq0_out_b),
    .dq0_valid(dq0_valid_b), .dq0_ch(dq0_ch_b), .busy(busy_b),
    .scan_in0(scan_in0), .scan_in1(scan_in1), .scan_in2(scan_in2),
    .scan_in3(scan_in3), .scan_in4(scan_in4), .scan_enable(scan_enable),
    .test_mode(test_mode), .scan_out0(so_b[0]), .scan_out1(so_b[1]),
    .scan_out2(so_b[2]), .scan_out3(so_b[3]), .scan_out4(so_b[4]),
    .state(state_b)
  );

  task automatic model_reset();
    m_last = 3; m_edge = 0; m_gedge = -1000;
    m_fa_dq = '0; m_out = '0; m_ch = '0;
    exp_ack = '0; exp_busy = 1'b0; exp_valid = 1'b0;
    exp_q.delete(); exp_ch_q.delete();
  endtask

  // Drive one cycle of inputs, advance one edge, update model expectations.
  task automatic cycle(input logic [3:0] r, input logic [63:0] d);
    int lat, w;
    logic [15:0] wd;
    lat = use_b ? 2 : 0;
    req_m = r; dq_m = d;
    exp_ack = '0;
    if (m_edge >= m_gedge + lat + 1 && r != 4'b0) begin
      w = -1;
      for (int k = 1; k <= 4; k++) if (w < 0 && r[(m_last + k) % 4]) w = (m_last + k) % 4;
      m_last = w;
      m_gedge = m_edge + 1;
      wd = d[w*16 +: 16];
      m_fa_dq = wd;
      exp_ack = 4'(1 << w);
      exp_q.push_back(use_b ? wd[10:0] : floata(wd));
      exp_ch_q.push_back(2'(w));
    end
    @(posedge clk); #1;
    m_edge++;
    exp_busy  = (m_edge >= m_gedge) && (m_edge <= m_gedge + lat);
    exp_valid = (m_edge == m_gedge + lat + 1);
    if (exp_valid) begin
      m_out = exp_q.pop_front();
      m_ch  = exp_ch_q.pop_front();
    end
  endtask

  task automatic do_reset(input logic sel);
    use_b = sel;
    req_m = '0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1; use_b = 1'b0; req_m = '0; dq_m = '0;
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({ack_a, ack_b, busy_a, busy_b, dq0_valid_a, dq0_valid_b} !== 10'b0) begin
      errors++; $display("FAIL reset_ctrl: got %h exp 0", {ack_a, ack_b, busy_a, busy_b, dq0_valid_a, dq0_valid_b});
    end
    checks++;
    if ({fa_dq_a, fa_dq_b, dq0_out_a, dq0_out_b, dq0_ch_a, dq0_ch_b} !== 58'b0) begin
      errors++; $display("FAIL reset_data: got %h exp 0", {fa_dq_a, fa_dq_b, dq0_out_a, dq0_out_b, dq0_ch_a, dq0_ch_b});
    end
    checks++;
    if (state_a !== IDLE || state_b !== IDLE) begin
      errors++; $display("FAIL reset_state: got %0d/%0d exp 0/0", state_a, state_b);
    end
    req_m = 4'hF; dq_m = {$urandom, $urandom};
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ack_a, busy_a, fa_dq_a} !== 21'b0) begin
      errors++; $display("FAIL reset_held: got %h exp 0", {ack_a, busy_a, fa_dq_a});
    end
    checks++;
    if ({so_a, so_b} !== 10'b0) begin
      errors++; $display("FAIL scan_out: got %h exp 0", {so_a, so_b});
    end
  endtask

  task automatic test_single();
    do_reset(1'b0);
    cycle(4'b0001, 64'h0);
    checks++;
    if (ack_m !== 4'b0001 || exp_ack !== 4'b0001) begin
      errors++; $display("FAIL single_ack: got %b exp 0001", ack_m);
    end
    cycle(4'b0000, 64'h0);
    checks++;
    if ({dq0_valid_m, dq0_ch_m, dq0_out_m} !== {1'b1, 2'd0, 11'h020}) begin
      errors++; $display("FAIL single_dq0: got %b/%0d/%h exp 1/0/020", dq0_valid_m, dq0_ch_m, dq0_out_m);
    end
  endtask

  task automatic test_all_req();
    logic [3:0] seq [8];
    int gcount, prev;
    int per_ch [4];
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    per_ch = '{0, 0, 0, 0};
    gcount = 0; prev = -1;
    do_reset(1'b0);
    for (int i = 0; i < 16; i++) begin
      cycle(4'hF, {$urandom, $urandom});
      checks++;
      if (ack_m !== exp_ack) begin
        errors++; $display("FAIL all_ack_model: cyc %0d got %b exp %b", i, ack_m, exp_ack);
      end
      if (dq0_valid_m === 1'b1) begin
        checks++;
        if (dq0_out_m !== m_out || dq0_ch_m !== m_ch) begin
          errors++; $display("FAIL all_dq0: got %h/%0d exp %h/%0d", dq0_out_m, dq0_ch_m, m_out, m_ch);
        end
      end
      if (ack_m !== 4'b0) begin
        if (gcount < 8) begin
          checks++;
          if (ack_m !== seq[gcount]) begin
            errors++; $display("FAIL all_seq: grant %0d got %b exp %b", gcount, ack_m, seq[gcount]);
          end
        end
        if (prev >= 0) begin
          checks++;
          if (i - prev != 2) begin
            errors++; $display("FAIL all_spacing: got %0d exp 2", i - prev);
          end
        end
        for (int c = 0; c < 4; c++) if (ack_m[c]) per_ch[c]++;
        prev = i; gcount++;
      end
    end
    checks++;
    if (gcount != 8 || per_ch[0] != 2 || per_ch[1] != 2 || per_ch[2] != 2 || per_ch[3] != 2) begin
      errors++; $display("FAIL all_fair: got %0d grants %0d/%0d/%0d/%0d exp 8 2/2/2/2",
                         gcount, per_ch[0], per_ch[1], per_ch[2], per_ch[3]);
    end
  endtask

  task automatic test_lat2();
    int n;
    do_reset(1'b1);
    cycle(4'b0100, 64'h0000_8000_0000_0000);
    checks++;
    if (ack_m !== 4'b0100 || fa_dq_m !== 16'h8000) begin
      errors++; $display("FAIL lat2_ack: got %b/%h exp 0100/8000", ack_m, fa_dq_m);
    end
    n = 0;
    while (dq0_valid_m !== 1'b1 && n < 8) begin
      cycle(4'b0000, 64'h0);
      n++;
    end
    checks++;
    if (n != 3) begin
      errors++; $display("FAIL lat2_latency: got %0d exp 3", n);
    end
    checks++;
    if (dq0_out_m !== 11'h000 || dq0_ch_m !== 2'd2) begin
      errors++; $display("FAIL lat2_dq0: got %h/%0d exp 000/2", dq0_out_m, dq0_ch_m);
    end
  endtask

  task automatic test_reset_abort();
    int seen;
    do_reset(1'b1);
    cycle(4'b0010, {$urandom, $urandom});
    checks++;
    if (ack_m !== 4'b0010 || busy_m !== 1'b1) begin
      errors++; $display("FAIL abort_grant: got %b/%b exp 0010/1", ack_m, busy_m);
    end
    req_m = 4'b0;
    reset = 1'b0;
    #1;
    checks++;
    if ({ack_m, busy_m, dq0_valid_m, fa_dq_m, dq0_out_m, dq0_ch_m} !== 35'b0 || state_m !== IDLE) begin
      errors++; $display("FAIL abort_outputs: got %h exp 0", {ack_m, busy_m, dq0_valid_m, fa_dq_m, dq0_out_m, dq0_ch_m});
    end
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    seen = 0;
    repeat (6) begin
      cycle(4'b0000, 64'h0);
      if (dq0_valid_m === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL abort_no_valid: got %0d exp 0", seen);
    end
    cycle(4'b0011, {$urandom, $urandom});
    checks++;
    if (ack_m !== 4'b0001) begin
      errors++; $display("FAIL abort_first: got %b exp 0001", ack_m);
    end
  endtask

  task automatic test_late_drop();
    logic [3:0] acc;
    do_reset(1'b1);
    cycle(4'b0001, {$urandom, $urandom});
    checks++;
    if (ack_m !== 4'b0001) begin
      errors++; $display("FAIL drop_first: got %b exp 0001", ack_m);
    end
    acc = '0;
    repeat (3) begin cycle(4'b1000, {$urandom, $urandom}); acc |= ack_m; end
    repeat (2) begin cycle(4'b0000, {$urandom, $urandom}); acc |= ack_m; end
    checks++;
    if (acc !== 4'b0) begin
      errors++; $display("FAIL drop_no_ack: got %b exp 0000", acc);
    end
    cycle(4'b1001, {$urandom, $urandom});
    checks++;
    if (ack_m !== 4'b1000 || ack_m !== exp_ack) begin
      errors++; $display("FAIL drop_last: got %b exp 1000", ack_m);
    end
  endtask

  task automatic test_repeat();
    do_reset(1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(4'b0010, {$urandom, $urandom});
      checks++;
      if (ack_m !== ((i % 2 == 0) ? 4'b0010 : 4'b0000) || busy_m !== (i % 2 == 0)) begin
        errors++; $display("FAIL repeat_cyc%0d: got %b/%b exp %b/%b", i, ack_m, busy_m,
                           (i % 2 == 0) ? 4'b0010 : 4'b0000, (i % 2 == 0));
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    for (int s = 0; s < 2; s++) begin
      do_reset(s[0]);
      for (int i = 0; i < 250; i++) begin
        r = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom_range(1, 15));
        cycle(r, {$urandom, $urandom});
        checks++;
        if (ack_m !== exp_ack || busy_m !== exp_busy || (state_m == WAIT) !== exp_busy) begin
          errors++; $display("FAIL rand_ctrl: lat%0d cyc %0d got %b/%b exp %b/%b", s * 2, i, ack_m, busy_m, exp_ack, exp_busy);
        end
        checks++;
        if (dq0_valid_m !== exp_valid || fa_dq_m !== m_fa_dq) begin
          errors++; $display("FAIL rand_valid_fa: lat%0d cyc %0d got %b/%h exp %b/%h", s * 2, i, dq0_valid_m, fa_dq_m, exp_valid, m_fa_dq);
        end
        checks++;
        if (dq0_out_m !== m_out || dq0_ch_m !== m_ch) begin
          errors++; $display("FAIL rand_dq0: lat%0d cyc %0d got %h/%0d exp %h/%0d", s * 2, i, dq0_out_m, dq0_ch_m, m_out, m_ch);
        end
      end
    end
  endtask

  initial begin
    {scan_in0, scan_in1, scan_in2, scan_in3, scan_in4, scan_enable, test_mode} = '0;
    model_reset();
    test_reset();
    test_single();
    test_all_req();
    test_lat2();
    test_reset_abort();
    test_late_drop();
    test_repeat();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/floata_sched.md
FLOATA_SCHED -- requirements
Module: floata_sched

Interface
- REQ-001 Parameter NCH, default 4: number of requesting channels; power of two, at least 2.
- REQ-002 Parameter FA_LAT, default 0: FLOATA latency in clk cycles from fa_dq to fa_dq0 (0 means combinational).
- REQ-003 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
- REQ-004 Port reset, input, 1 bit: asynchronous, active-low reset.
- REQ-005 Port req, input, NCH bits: per-channel conversion request, held high until acked.
- REQ-006 Port dq_in, input, NCH*16 bits: per-channel 16-bit sign-magnitude DQ; channel i occupies bits [16i+15:16i].
- REQ-007 Port ack, output, NCH bits: one-hot, one-cycle grant pulse; the sample of that channel has been captured.
- REQ-008 Port fa_dq, output, 16 bits: registered DQ driven to the shared FLOATA instance.
- REQ-009 Port fa_dq0, input, 11 bits: DQ0 returned by FLOATA.
- REQ-010 Port dq0_out, output, 11 bits: captured conversion result.
- REQ-011 Port dq0_valid, output, 1 bit: one-cycle pulse qualifying dq0_out and dq0_ch.
- REQ-012 Port dq0_ch, output, log2(NCH) bits: channel that owns dq0_out.
- REQ-013 Port busy, output, 1 bit: high whenever the state is not IDLE.
- REQ-014 Ports scan_in0..4 and scan_enable/test_mode (inputs) and scan_out0..4 (outputs) SHALL be present; they have no functional use, and scan_out0..4 are tied to 0 pre-insertion.

Function
- REQ-015 The FSM SHALL have two states, IDLE and WAIT.
- REQ-016 IDLE with req==0: the block SHALL stay in IDLE and hold all registers.
- REQ-017 IDLE with any req bit set: at the next edge the block SHALL grant one winner w.
  - pulse ack[w] for one cycle;
  - load fa_dq from dq_in slice w and latch w as the owner;
  - load cnt with FA_LAT and enter WAIT.
- REQ-018 Arbitration SHALL be round-robin.
  - Search starts at (last+1) mod NCH, where last is the most recently granted channel.
  - last resets to NCH-1, so channel 0 has first priority after reset.
- REQ-019 WAIT with cnt!=0: the block SHALL decrement cnt.
- REQ-020 WAIT with cnt==0: at the next edge the block SHALL capture fa_dq0 into dq0_out, set dq0_ch to the owner, pulse dq0_valid, and return to IDLE.
- REQ-021 Timing:
  - Grant-to-dq0_valid latency SHALL be FA_LAT+1 cycles.
  - Minimum spacing between grants SHALL be FA_LAT+2 cycles.
- REQ-022 No ack SHALL be issued while in WAIT.
  - A req that falls before it is granted is simply dropped, with no error.
  - A req that rises during WAIT is considered at the next IDLE cycle.
- REQ-023 fa_dq, dq0_out and dq0_ch SHALL hold their last values until the next grant or capture.
- REQ-024 The counter SHALL be ceil(log2(FA_LAT+1)) bits wide, minimum 1, and SHALL never underflow.
- REQ-025 When all NCH channels request continuously, each channel SHALL receive exactly one grant per NCH grants.

Reset
- REQ-026 While reset is low, the block SHALL force state=IDLE, cnt=0, last=NCH-1, ack=0, fa_dq=0, dq0_out=0, dq0_ch=0, dq0_valid=0 and busy=0, independent of clk.
- REQ-027 A reset asserted during WAIT SHALL abort the conversion: no dq0_valid is ever produced for that grant.
- REQ-028 The first grant after reset release SHALL occur no earlier than the first rising edge with reset high.

Structure
- REQ-029 Package floata_pkg SHALL hold the constants DQ_W=16 and DQ0_W=11, and the FSM state enum {IDLE, WAIT}.
- REQ-030 Round-robin selection SHALL be the sub-module rr_arbiter.
  - Inputs: req and last.
  - Outputs: a one-hot winner and its index; purely combinational.
- REQ-031 FLOATA SHALL NOT be instantiated inside floata_sched; it is connected at the parent level.

Verification
- REQ-032 Scenario: FA_LAT=0 with the real FLOATA; req=0001, dq_in ch0=0x0000.
  - ack=0001 one cycle after request.
  - One cycle later dq0_valid=1, dq0_ch=0, dq0_out=0x020.
- REQ-033 Scenario: FA_LAT=0; req=1111 held for 8 grants.
  - ack sequence 0001,0010,0100,1000,0001,0010,0100,1000.
  - Grants spaced 2 cycles apart.
- REQ-034 Scenario: FA_LAT=2 with a stub that echoes fa_dq[10:0] after 2 cycles; ch2 sends 0x8000.
  - dq0_valid exactly 3 cycles after ack[2].
  - dq0_out=0x000, dq0_ch=2.
- REQ-035 Scenario: reset pulsed low during WAIT after a ch1 grant.
  - No dq0_valid.
  - All outputs 0 while reset is low.
  - With req=0011 after release, ack goes to ch0 first.
- REQ-036 Scenario: ch3 raises req during WAIT, then drops it before IDLE.
  - No ack[3].
  - last unchanged.
- REQ-037 Scenario: FA_LAT=0; ch1 requests alone, repeatedly.
  - ack[1] every 2 cycles.
  - busy alternates 1,0.
